pe_out_sched: RTL and testbench
===============================

# pe_out_sched

Sequencer for the binary output layer. It time-multiplexes one shared PE_OUT datapath over N_CLASS output kernels for each incoming pixel window. For each class it fetches that class's weights, norm_ref and scale from a parameter memory, drives the PE for one cycle, and keeps a running signed argmax. It emits the winning class label with a valid/ready handshake. It sits between the last binary conv stage (window source) and the label/pixel writer.

## Interface
Parameters:
- D, 512: channels per window
- FH / FW, 3 / 3: window height / width
- N_CLASS, 11: output classes, at least 1
- NORMREF_WIDTH, 13: norm_ref width, equal to the PE conv width
- NORMREF_SCALE_WIDTH, 13: scale width
- Derived: WIN_W = D*FH*FW; OUT_WIDTH = NORMREF_WIDTH+NORMREF_SCALE_WIDTH; CLS_W = max(1,$clog2(N_CLASS))

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-high
- win_valid  in  1  window available
- win_ready  out  1  block accepts window
- win_data  in  WIN_W  binary window
- par_rd  out  1  parameter memory read strobe
- par_addr  out  CLS_W  class index to read
- par_weight  in  WIN_W  kernel weights, valid 1 cycle after par_rd
- par_norm_ref  in  NORMREF_WIDTH  valid 1 cycle after par_rd
- par_scale  in  NORMREF_SCALE_WIDTH  valid 1 cycle after par_rd
- pe_data_in  out  WIN_W  to PE data_in
- pe_weight_in  out  WIN_W  to PE weight_in
- pe_norm_ref  out  NORMREF_WIDTH  to PE norm_ref
- pe_scale  out  NORMREF_SCALE_WIDTH  to PE scale
- pe_in_en  out  1  to PE in_en
- pe_data_out  in  OUT_WIDTH  PE score, signed, combinational from PE inputs
- label_valid  out  1  label available
- label_ready  in  1  consumer accepts label
- label  out  CLS_W  argmax class
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, FETCH, EVAL, DONE. Reset puts the FSM in IDLE.
- IDLE:
  - win_ready = 1 (forced 0 while rst is high).
  - On win_valid: register win_data into the window register, set cls = 0, pulse par_rd with par_addr = 0, go to FETCH.
- FETCH: register par_weight, par_norm_ref and par_scale into the PE-facing registers; go to EVAL.
- EVAL:
  - pe_in_en = 1. Sample pe_data_out as a signed value at the end of the cycle.
  - cls == 0: load it unconditionally as the best score/index.
  - Otherwise: replace the best only if the score is strictly greater. Ties keep the lower index.
  - If cls < N_CLASS-1: pulse par_rd with par_addr = cls+1, increment cls, go to FETCH. Otherwise go to DONE.
- DONE:
  - label_valid = 1; label = best index, held stable.
  - On label_ready: go to IDLE.
- pe_data_in always equals the window register. pe_in_en = 0 outside EVAL. par_rd = 0 except in the cycles listed above.
- Reset values: all outputs and registers are 0 (label_valid, par_rd, pe_in_en, busy, label, pe_* all 0). win_ready is 0 during rst and 1 in the first cycle after rst falls.
- Reset asserted mid-window: the window is abandoned, no label is produced, and there is no par_rd in the cycle after.

## Timing
- Window accepted at cycle t0 (win_valid & win_ready).
- Class k: FETCH at t0+1+2k, EVAL at t0+2+2k.
- label_valid rises at t0+2*N_CLASS+1.
- Minimum window period: 2*N_CLASS+2 cycles (DONE with label_ready, then IDLE).
- Back-pressure: DONE is held indefinitely and win_ready stays 0 until the label is taken.
- win_valid is ignored outside IDLE.

## Configuration
- PE_OUT_SCORE_EN defined: adds output port label_score [OUT_WIDTH-1:0], the winning signed score. It is valid and stable with label_valid and resets to 0.
- Not defined: the port is absent. The best-score register still exists internally for comparison.

## Structure
- Shared package pe_out_pkg holds:
  - the FSM state enum;
  - default width constants (NORMREF_WIDTH, NORMREF_SCALE_WIDTH);
  - the OUT_WIDTH and CLS_W derivation functions.
- One sub-module, score_argmax, holds the best score/index registers:
  - inputs: clear/first, enable, score, index;
  - outputs: best_idx, best_score;
  - signed strict-greater compare.
- The FSM, cls counter, window register and PE-facing registers live in pe_out_sched.

## Test plan
All scenarios use N_CLASS=4 unless stated. The bench models the PE and parameter memory behaviourally.
- Scores [-5,12,12,3], window accepted at t0 -> label 1 (tie keeps lower index); label_valid exactly at t0+9; par_addr sequence 0,1,2,3.
- All-negative scores [-7,-3,-9,-100] -> label 1; with PE_OUT_SCORE_EN, label_score = -3.
- label_ready held low 5 cycles after label_valid -> label stable, win_ready 0, win_valid ignored; accepted on the 6th cycle; win_ready 1 the next cycle.
- rst asserted during class-2 EVAL -> next cycle FSM in IDLE, label_valid 0, par_rd 0, pe_in_en 0, win_ready 1 after rst falls; the next window completes normally.
- N_CLASS=1, score 42 -> label 0 at t0+3; par_rd pulses exactly once.
- Back-to-back windows with win_valid always high -> second accept exactly 2*N_CLASS+2 = 10 cycles after the first.

Source files
------------

// File: rtl/pe_out_pkg.sv
// Shared types and width helpers for the output-layer scheduler.
package pe_out_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EVAL  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_NORMREF_WIDTH       = 13;
  localparam int DEF_NORMREF_SCALE_WIDTH = 13;

  // PE score width: conv width plus scale width
  function automatic int out_width(input int nr_w, input int sc_w);
    return nr_w + sc_w;
  endfunction

  // Class index width, never below one bit
  function automatic int cls_width(input int n_class);
    return (n_class > 1) ? $clog2(n_class) : 1;
  endfunction

endpackage

// File: rtl/pe_out_sched_if.sv
// Window, parameter-memory, PE and label signals of the output scheduler.
// master = scheduler side, slave = surrounding system (source, memory, PE, sink).
interface pe_out_sched_if
  import pe_out_pkg::*;
#(
  parameter int WIN_W               = 512 * 3 * 3,
  parameter int NORMREF_WIDTH       = DEF_NORMREF_WIDTH,
  parameter int NORMREF_SCALE_WIDTH = DEF_NORMREF_SCALE_WIDTH,
  parameter int CLS_W               = cls_width(11)
);
  localparam int OUT_WIDTH = out_width(NORMREF_WIDTH, NORMREF_SCALE_WIDTH);

  logic                           win_valid;
  logic                           win_ready;
  logic [WIN_W-1:0]               win_data;
  logic                           par_rd;
  logic [CLS_W-1:0]               par_addr;
  logic [WIN_W-1:0]               par_weight;
  logic [NORMREF_WIDTH-1:0]       par_norm_ref;
  logic [NORMREF_SCALE_WIDTH-1:0] par_scale;
  logic [WIN_W-1:0]               pe_data_in;
  logic [WIN_W-1:0]               pe_weight_in;
  logic [NORMREF_WIDTH-1:0]       pe_norm_ref;
  logic [NORMREF_SCALE_WIDTH-1:0] pe_scale;
  logic                           pe_in_en;
  logic [OUT_WIDTH-1:0]           pe_data_out;
  logic                           label_valid;
  logic                           label_ready;
  logic [CLS_W-1:0]               label;
  logic                           busy;

  modport master (
    input  win_valid, win_data, par_weight, par_norm_ref, par_scale,
           pe_data_out, label_ready,
    output win_ready, par_rd, par_addr, pe_data_in, pe_weight_in,
           pe_norm_ref, pe_scale, pe_in_en, label_valid, label, busy
  );

  modport slave (
    output win_valid, win_data, par_weight, par_norm_ref, par_scale,
           pe_data_out, label_ready,
    input  win_ready, par_rd, par_addr, pe_data_in, pe_weight_in,
           pe_norm_ref, pe_scale, pe_in_en, label_valid, label, busy
  );

endinterface

// File: rtl/score_argmax.sv
// Running signed argmax over the per-class PE scores of one window.
module score_argmax #(
  parameter int SCORE_W = 26,
  parameter int IDX_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      first,
  input  logic                      en,
  input  logic signed [SCORE_W-1:0] score,
  input  logic [IDX_W-1:0]          idx,
  output logic [IDX_W-1:0]          best_idx,
  output logic signed [SCORE_W-1:0] best_score
);

  // First class loads unconditionally; later ones only on strictly greater, so ties keep the lower index
  always_ff @(posedge clk) begin
    if (rst) begin
      best_idx   <= '0;
      best_score <= '0;
    end else if (en && (first || (score > best_score))) begin
      best_idx   <= idx;
      best_score <= score;
    end
  end

endmodule

// File: rtl/pe_out_sched.sv
// Output-layer scheduler: walks N_CLASS kernels through one shared PE per
// window and reports the argmax class with a valid/ready handshake.
// Optional macro PE_OUT_SCORE_EN adds the label_score output (winning score).
//
// state | meaning
// IDLE  | waiting for a window; accepting it issues the class-0 fetch
// FETCH | parameter memory data arrives and is registered towards the PE
// EVAL  | PE driven for one cycle; score folded into the argmax, next fetch issued
// DONE  | label presented until the consumer takes it
module pe_out_sched
  import pe_out_pkg::*;
#(
  parameter int D                   = 512,
  parameter int FH                  = 3,
  parameter int FW                  = 3,
  parameter int N_CLASS             = 11,
  parameter int NORMREF_WIDTH       = DEF_NORMREF_WIDTH,
  parameter int NORMREF_SCALE_WIDTH = DEF_NORMREF_SCALE_WIDTH
) (
  input  logic clk,
  input  logic rst,
  pe_out_sched_if.master bus
`ifdef PE_OUT_SCORE_EN
  ,
  output logic signed [NORMREF_WIDTH+NORMREF_SCALE_WIDTH-1:0] label_score
`endif
);

  localparam int WIN_W     = D * FH * FW;
  localparam int OUT_WIDTH = out_width(NORMREF_WIDTH, NORMREF_SCALE_WIDTH);
  localparam int CLS_W     = cls_width(N_CLASS);
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(N_CLASS - 1);

  state_t                         state;
  state_t                         state_next;
  logic [CLS_W-1:0]               cls;
  logic [WIN_W-1:0]               win_reg;
  logic [WIN_W-1:0]               weight_reg;
  logic [NORMREF_WIDTH-1:0]       norm_ref_reg;
  logic [NORMREF_SCALE_WIDTH-1:0] scale_reg;
  logic                           accept;
  logic                           last_cls;
  logic [CLS_W-1:0]               best_idx;

  assign last_cls = (cls == LAST_CLS);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and parameter-read strobe; a reset cycle never issues a read
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    bus.par_rd   = 1'b0;
    bus.par_addr = '0;
    unique case (state)
      IDLE: begin
        if (bus.win_valid) begin
          accept     = 1'b1;
          bus.par_rd = 1'b1;
          state_next = FETCH;
        end
      end
      FETCH: state_next = EVAL;
      EVAL: begin
        if (!last_cls) begin
          bus.par_rd   = 1'b1;
          bus.par_addr = cls + 1'b1;
          state_next   = FETCH;
        end else begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.label_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      accept     = 1'b0;
      bus.par_rd = 1'b0;
    end
  end

  // Window capture and class counter
  always_ff @(posedge clk) begin
    if (rst) begin
      win_reg <= '0;
      cls     <= '0;
    end else if (accept) begin
      win_reg <= bus.win_data;
      cls     <= '0;
    end else if ((state == EVAL) && !last_cls) begin
      cls <= cls + 1'b1;
    end
  end

  // PE-facing parameter registers, loaded from the memory read issued one cycle earlier
  always_ff @(posedge clk) begin
    if (rst) begin
      weight_reg   <= '0;
      norm_ref_reg <= '0;
      scale_reg    <= '0;
    end else if (state == FETCH) begin
      weight_reg   <= bus.par_weight;
      norm_ref_reg <= bus.par_norm_ref;
      scale_reg    <= bus.par_scale;
    end
  end

`ifdef PE_OUT_SCORE_EN
  score_argmax #(.SCORE_W(OUT_WIDTH), .IDX_W(CLS_W)) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .first      (cls == '0),
    .en         (state == EVAL),
    .score      (bus.pe_data_out),
    .idx        (cls),
    .best_idx   (best_idx),
    .best_score (label_score)
  );
`else
  // Best score is only needed inside the argmax for comparison
  logic signed [OUT_WIDTH-1:0] best_score_unused;

  score_argmax #(.SCORE_W(OUT_WIDTH), .IDX_W(CLS_W)) u_argmax (
    .clk        (clk),
    .rst        (rst),
    .first      (cls == '0),
    .en         (state == EVAL),
    .score      (bus.pe_data_out),
    .idx        (cls),
    .best_idx   (best_idx),
    .best_score (best_score_unused)
  );
`endif

  assign bus.win_ready    = (state == IDLE) && !rst;
  assign bus.busy         = (state != IDLE);
  assign bus.pe_in_en     = (state == EVAL);
  assign bus.label_valid  = (state == DONE);
  assign bus.label        = best_idx;
  assign bus.pe_data_in   = win_reg;
  assign bus.pe_weight_in = weight_reg;
  assign bus.pe_norm_ref  = norm_ref_reg;
  assign bus.pe_scale     = scale_reg;

endmodule

// File: tb/tb_pe_out_sched.sv
// Bench for pe_out_sched: N_CLASS=4 and N_CLASS=1 instances with behavioural
// parameter memory and PE. Honours PE_OUT_SCORE_EN for label_score checks.
module tb_pe_out_sched;

  localparam int D = 2, FH = 3, FW = 3;
  localparam int WIN_W = D * FH * FW;
  localparam int NRW = 13, SCW = 13, OW = NRW + SCW;
  localparam int NA = 4, CWA = 2;
  localparam int NB = 1, CWB = 1;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0, checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_out_sched_if #(.WIN_W(WIN_W), .NORMREF_WIDTH(NRW), .NORMREF_SCALE_WIDTH(SCW), .CLS_W(CWA)) ifa ();
  pe_out_sched_if #(.WIN_W(WIN_W), .NORMREF_WIDTH(NRW), .NORMREF_SCALE_WIDTH(SCW), .CLS_W(CWB)) ifb ();

`ifdef PE_OUT_SCORE_EN
  logic signed [OW-1:0] score_a, score_b;
`endif

  pe_out_sched #(.D(D), .FH(FH), .FW(FW), .N_CLASS(NA),
                 .NORMREF_WIDTH(NRW), .NORMREF_SCALE_WIDTH(SCW)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
`ifdef PE_OUT_SCORE_EN
    , .label_score (score_a)
`endif
  );

  pe_out_sched #(.D(D), .FH(FH), .FW(FW), .N_CLASS(NB),
                 .NORMREF_WIDTH(NRW), .NORMREF_SCALE_WIDTH(SCW)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
`ifdef PE_OUT_SCORE_EN
    , .label_score (score_b)
`endif
  );

  // Parameter memories: data appears one cycle after the read strobe
  logic [WIN_W-1:0] mem_w_a [NA];
  logic [NRW-1:0]   mem_nr_a[NA];
  logic [SCW-1:0]   mem_sc_a[NA];
  logic [WIN_W-1:0] mem_w_b;
  logic [NRW-1:0]   mem_nr_b;
  logic [SCW-1:0]   mem_sc_b;

  always @(posedge clk) begin
    if (ifa.par_rd) begin
      ifa.par_weight   <= mem_w_a[ifa.par_addr];
      ifa.par_norm_ref <= mem_nr_a[ifa.par_addr];
      ifa.par_scale    <= mem_sc_a[ifa.par_addr];
    end
    if (ifb.par_rd) begin
      ifb.par_weight   <= mem_w_b;
      ifb.par_norm_ref <= mem_nr_b;
      ifb.par_scale    <= mem_sc_b;
    end
  end

  // Behavioural PE: xnor-popcount times signed scale plus signed norm_ref
  function automatic logic signed [OW-1:0] pe_model(input logic [WIN_W-1:0] d, input logic [WIN_W-1:0] w,
                                                    input logic [NRW-1:0] nr, input logic [SCW-1:0] sc);
    int pc;
    pc = $countones(~(d ^ w));
    return OW'(pc * int'($signed(sc)) + int'($signed(nr)));
  endfunction

  assign ifa.pe_data_out = pe_model(ifa.pe_data_in, ifa.pe_weight_in, ifa.pe_norm_ref, ifa.pe_scale);
  assign ifb.pe_data_out = pe_model(ifb.pe_data_in, ifb.pe_weight_in, ifb.pe_norm_ref, ifb.pe_scale);

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference argmax: first highest score wins
  function automatic void ref_argmax(input logic [WIN_W-1:0] win, output int lbl, output longint best);
    longint s;
    lbl  = 0;
    best = 0;
    for (int k = 0; k < NA; k++) begin
      s = longint'(pe_model(win, mem_w_a[k], mem_nr_a[k], mem_sc_a[k]));
      if (k == 0 || s > best) begin
        best = s;
        lbl  = k;
      end
    end
  endfunction

  // Monitor: records accepts/reads and checks what the PE is being fed
  int               acc_a[$];
  int               prd_a_cyc[$];
  int               prd_a_addr[$];
  int               prd_b_n = 0;
  int               cls_a = 0;
  logic [WIN_W-1:0] cur_win_a = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifa.pe_in_en) begin
        chk("pe_data_in", longint'(ifa.pe_data_in), longint'(cur_win_a));
        chk("pe_weight_in", longint'(ifa.pe_weight_in), longint'(mem_w_a[cls_a]));
        chk("pe_norm_ref", longint'(ifa.pe_norm_ref), longint'(mem_nr_a[cls_a]));
      end
      if (ifa.win_valid && ifa.win_ready) acc_a.push_back(cyc);
      if (ifa.par_rd) begin
        prd_a_cyc.push_back(cyc);
        prd_a_addr.push_back(int'(ifa.par_addr));
        cls_a = int'(ifa.par_addr);
      end
      if (ifb.par_rd) prd_b_n++;
    end
  end

  task automatic load_scores(input logic [WIN_W-1:0] win, input int s0, input int s1, input int s2, input int s3);
    int s[NA];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < NA; k++) begin
      mem_w_a[k]  = ~win;
      mem_nr_a[k] = NRW'(s[k]);
      mem_sc_a[k] = SCW'($urandom);
    end
  endtask

  // One full window on the N_CLASS=4 instance with timing and read-sequence checks
  task automatic run_a(input logic [WIN_W-1:0] win, input int exp_lbl, input longint exp_sc);
    int t0, tl;
    bit seen;
    t0 = 0;
    tl = 0;
    prd_a_cyc.delete();
    prd_a_addr.delete();
    @(posedge clk); #1;
    cur_win_a     = win;
    ifa.win_data  = win;
    ifa.win_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifa.win_ready) begin seen = 1; t0 = cyc; end
    end
    chk("accept_seen", longint'(seen), 1);
    @(posedge clk); #1;
    ifa.win_valid = 1'b0;
    ifa.win_data  = ~win;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ifa.label_valid) begin seen = 1; tl = cyc; end
    end
    chk("label_valid_seen", longint'(seen), 1);
    chk("label_valid_time", tl - t0, 2 * NA + 1);
    chk("label", longint'(ifa.label), exp_lbl);
`ifdef PE_OUT_SCORE_EN
    chk("label_score", longint'(score_a), exp_sc);
`endif
    chk("par_rd_count", prd_a_cyc.size(), NA);
    for (int k = 0; k < NA && k < prd_a_cyc.size(); k++) begin
      chk("par_addr_seq", prd_a_addr[k], k);
      chk("par_rd_time", prd_a_cyc[k] - t0, 2 * k);
    end
    #1 ifa.label_ready = 1'b1;
    @(posedge clk); #1;
    ifa.label_ready = 1'b0;
  endtask

  typedef struct {
    int s0, s1, s2, s3;
    int lbl;
    int best;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int t0, tl, lbl;
    longint best;
    bit seen;
    logic [WIN_W-1:0] w;

    tbl[0] = '{s0: -5,    s1: 12,    s2: 12,   s3: 3,    lbl: 1, best: 12};
    tbl[1] = '{s0: -7,    s1: -3,    s2: -9,   s3: -100, lbl: 1, best: -3};
    tbl[2] = '{s0: 0,     s1: 0,     s2: 0,    s3: 0,    lbl: 0, best: 0};
    tbl[3] = '{s0: 1,     s1: 2,     s2: 3,    s3: 4,    lbl: 3, best: 4};
    tbl[4] = '{s0: 4,     s1: 3,     s2: 2,    s3: 1,    lbl: 0, best: 4};
    tbl[5] = '{s0: -4096, s1: -4096, s2: 4095, s3: 4095, lbl: 2, best: 4095};
    tbl[6] = '{s0: 5,     s1: -1,    s2: 5,    s3: 6,    lbl: 3, best: 6};

    rst = 1'b1;
    ifa.win_valid = 1'b0; ifa.win_data = '0; ifa.label_ready = 1'b0;
    ifb.win_valid = 1'b0; ifb.win_data = '0; ifb.label_ready = 1'b0;
    for (int k = 0; k < NA; k++) begin mem_w_a[k] = '0; mem_nr_a[k] = '0; mem_sc_a[k] = '0; end
    mem_w_b = '0; mem_nr_b = '0; mem_sc_b = '0;

    // Reset state, with a window offered during reset
    repeat (2) @(posedge clk);
    #1 ifa.win_valid = 1'b1;
    @(negedge clk);
    chk("rst_win_ready", longint'(ifa.win_ready), 0);
    chk("rst_par_rd", longint'(ifa.par_rd), 0);
    chk("rst_label_valid", longint'(ifa.label_valid), 0);
    chk("rst_busy", longint'(ifa.busy), 0);
    chk("rst_pe_in_en", longint'(ifa.pe_in_en), 0);
    chk("rst_label", longint'(ifa.label), 0);
    chk("rst_pe_regs", longint'(ifa.pe_data_in) + longint'(ifa.pe_weight_in)
                       + longint'(ifa.pe_norm_ref) + longint'(ifa.pe_scale), 0);
`ifdef PE_OUT_SCORE_EN
    chk("rst_label_score", longint'(score_a), 0);
`endif
    @(posedge clk); #1;
    ifa.win_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk("win_ready_after_rst", longint'(ifa.win_ready), 1);
    chk("busy_after_rst", longint'(ifa.busy), 0);

    // Directed score table
    foreach (tbl[i]) begin
      w = WIN_W'($urandom);
      load_scores(w, tbl[i].s0, tbl[i].s1, tbl[i].s2, tbl[i].s3);
      run_a(w, tbl[i].lbl, longint'(tbl[i].best));
    end

    // Randomized windows and parameters against the reference argmax
    for (int n = 0; n < 20; n++) begin
      w = WIN_W'($urandom);
      for (int k = 0; k < NA; k++) begin
        mem_w_a[k]  = ($urandom_range(0, 3) == 0 && k > 0) ? mem_w_a[0] : WIN_W'($urandom);
        mem_nr_a[k] = NRW'(int'($urandom_range(0, 16)) - 8);
        mem_sc_a[k] = ($urandom_range(0, 4) == 0) ? SCW'($urandom) : SCW'($urandom_range(0, 3));
      end
      ref_argmax(w, lbl, best);
      run_a(w, lbl, best);
    end

    // Back-pressure: label held 5 cycles, taken on the 6th, new window offered throughout
    w = WIN_W'($urandom);
    load_scores(w, 1, 9, 2, 3);
    @(posedge clk); #1;
    cur_win_a = w; ifa.win_data = w; ifa.win_valid = 1'b1;
    seen = 0; t0 = 0; tl = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifa.win_ready) begin seen = 1; t0 = cyc; end
    end
    chk("bp_accept_seen", longint'(seen), 1);
    @(posedge clk); #1 ifa.win_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ifa.label_valid) begin seen = 1; tl = cyc; end
    end
    chk("bp_label_time", tl - t0, 2 * NA + 1);
    chk("bp_label", longint'(ifa.label), 1);
    acc_a.delete();
    #1;
    w = WIN_W'($urandom);
    load_scores(w, -2, -1, 7, 7);
    cur_win_a = w; ifa.win_data = w; ifa.win_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("bp_label_stable", longint'(ifa.label), 1);
      chk("bp_label_valid_held", longint'(ifa.label_valid), 1);
      chk("bp_win_ready_low", longint'(ifa.win_ready), 0);
      chk("bp_no_par_rd", longint'(ifa.par_rd), 0);
    end
    #1 ifa.label_ready = 1'b1;
    @(posedge clk); #1 ifa.label_ready = 1'b0;
    @(negedge clk);
    chk("bp_win_ready_next", longint'(ifa.win_ready), 1);
    @(posedge clk); #1 ifa.win_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (ifa.label_valid) seen = 1;
    end
    chk("bp_second_label", longint'(ifa.label), 2);
    chk("bp_accept_count", acc_a.size(), 1);
    if (acc_a.size() > 0) chk("bp_accept_time", acc_a[0] - tl, 6);
    #1 ifa.label_ready = 1'b1;
    @(posedge clk); #1 ifa.label_ready = 1'b0;

    // Reset during class-2 EVAL abandons the window
    w = WIN_W'($urandom);
    load_scores(w, 3, 4, 5, 6);
    @(posedge clk); #1;
    cur_win_a = w; ifa.win_data = w; ifa.win_valid = 1'b1;
    seen = 0; t0 = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifa.win_ready) begin seen = 1; t0 = cyc; end
    end
    chk("mr_accept_seen", longint'(seen), 1);
    @(posedge clk); #1 ifa.win_valid = 1'b0;
    for (int i = 0; i < 20 && cyc < t0 + 6; i++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mr_in_eval", longint'(ifa.pe_in_en), 1);
    chk("mr_par_rd_gated", longint'(ifa.par_rd), 0);
    @(negedge clk);
    chk("mr_busy", longint'(ifa.busy), 0);
    chk("mr_label_valid", longint'(ifa.label_valid), 0);
    chk("mr_par_rd", longint'(ifa.par_rd), 0);
    chk("mr_pe_in_en", longint'(ifa.pe_in_en), 0);
    chk("mr_win_ready_in_rst", longint'(ifa.win_ready), 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mr_win_ready", longint'(ifa.win_ready), 1);
    repeat (2) begin
      @(negedge clk);
      chk("mr_no_label", longint'(ifa.label_valid), 0);
    end
    w = WIN_W'($urandom);
    load_scores(w, -1, 20, 21, -30);
    run_a(w, 2, 21);

    // Back-to-back windows with win_valid and label_ready held high
    w = WIN_W'($urandom);
    load_scores(w, 8, 2, 8, 1);
    acc_a.delete();
    @(posedge clk); #1;
    cur_win_a = w; ifa.win_data = w; ifa.win_valid = 1'b1; ifa.label_ready = 1'b1;
    for (int i = 0; i < 40 && acc_a.size() < 2; i++) @(posedge clk);
    #1 ifa.win_valid = 1'b0;
    chk("b2b_accepts", acc_a.size(), 2);
    if (acc_a.size() >= 2) chk("b2b_period", acc_a[1] - acc_a[0], 2 * NA + 2);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (!ifa.busy) seen = 1;
    end
    chk("b2b_drained", longint'(seen), 1);
    chk("b2b_label", longint'(ifa.label), 0);
    #1 ifa.label_ready = 1'b0;

    // Single-class instance
    w = WIN_W'($urandom);
    mem_w_b = ~w; mem_nr_b = NRW'(42); mem_sc_b = SCW'($urandom);
    prd_b_n = 0;
    @(posedge clk); #1;
    ifb.win_data = w; ifb.win_valid = 1'b1;
    seen = 0; t0 = 0; tl = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifb.win_ready) begin seen = 1; t0 = cyc; end
    end
    chk("n1_accept_seen", longint'(seen), 1);
    @(posedge clk); #1 ifb.win_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ifb.label_valid) begin seen = 1; tl = cyc; end
    end
    chk("n1_label_time", tl - t0, 3);
    chk("n1_label", longint'(ifb.label), 0);
`ifdef PE_OUT_SCORE_EN
    chk("n1_label_score", longint'(score_b), 42);
`endif
    #1 ifb.label_ready = 1'b1;
    @(posedge clk); #1 ifb.label_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("n1_par_rd_once", prd_b_n, 1);
    chk("n1_idle", longint'(ifb.busy), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
